regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter that shares the single integer register-file write port between NUM_SRC execution units (ALU, LSU, MUL/DIV, CSR).
- Uses round-robin arbitration with a per-source valid/ready handshake.
- Registers the winning write and drives the regfile write port one cycle later.
- Exports a pending-write mask that issue logic uses for RAW/WAW hazard checks.

Parameters:
- NUM_SRC, 4, number of write-back requesters (must be ≥2).
- DATA_WIDTH, 64, register data width.
- REG_NUM, 32, number of integer registers; address width is ADDR_W = $clog2(REG_NUM).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous pipeline flush; drops all pending requests.
- src_valid  input  NUM_SRC  per-source write request.
- src_addr  input  NUM_SRC*ADDR_W  per-source destination register, packed; source i occupies slice [i*ADDR_W +: ADDR_W].
- src_data  input  NUM_SRC*DATA_WIDTH  per-source write data, packed the same way.
- src_ready  output  NUM_SRC  per-source accept, one-hot or zero.
- wb_write  output  1  regfile write enable.
- wb_addr  output  ADDR_W  regfile write address.
- wb_data  output  DATA_WIDTH  regfile write data.
- pend_mask  output  REG_NUM  registers with an outstanding write.
- wait_cnt  output  NUM_SRC*32  per-source stall counters (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): wb_write=0, wb_addr=0, wb_data=0, rr_ptr=0, wait_cnt=0 take effect immediately, mid-transfer included. src_ready=0 and pend_mask=0 while in reset.
- Arbitration (combinational):
  - Search starts at rr_ptr and wraps modulo NUM_SRC.
  - The first i with src_valid[i]=1 is granted; src_ready[i]=1 for that i only, in the same cycle.
  - No valid request: src_ready=0.
- Accept (accepted = |src_ready) at posedge; g is the granted index:
  - wb_write <= (addr_g != 0); wb_addr <= addr_g; wb_data <= data_g.
  - rr_ptr <= (g+1) mod NUM_SRC.
- No accept at posedge:
  - wb_write <= 0; wb_addr/wb_data hold their previous values; rr_ptr holds.
- Latency: exactly 1 cycle from the accepting edge to wb_write=1. Throughput is 1 write per cycle, never stalls downstream.
- x0 target:
  - The request is accepted normally (ready=1) and rr_ptr advances.
  - wb_write stays 0 next cycle.
  - The request never sets pend_mask[0]; pend_mask[0] is constant 0.
- Source protocol:
  - Once src_valid is asserted, the source holds valid/addr/data stable until ready.
  - The bench asserts this; the arbiter does not check it.
- Fairness: with all sources continuously valid, grants rotate 0,1,…,NUM_SRC-1,0. Maximum wait is NUM_SRC-1 cycles.
- Same-address conflict (two sources, same rd, same cycle): serialized in round-robin order. The later grant is the final regfile value; no merging.
- flush=1:
  - src_ready=0 that cycle; nothing accepted.
  - At the edge: wb_write <= 0, rr_ptr <= 0.
  - A wb_write already registered (=1 during the flush cycle) still completes.
- pend_mask (combinational), bit r (r≠0) is set when either:
  - some source has src_valid=1 and addr=r, or
  - wb_write=1 and wb_addr=r.
- Overflow: src_addr values ≥ REG_NUM are impossible by construction (ADDR_W bits).

Optional Feature:
REGFILE_WB_ARB_PERF_EN
- Defined:
  - Each source has a 32-bit wait_cnt slice.
  - The slice increments every cycle with src_valid=1 and src_ready=0, flush cycles included.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: wait_cnt is tied to 0 and no counter flops are instantiated. Port list is identical in both builds.

Decomposition:
- Package regfile_wb_pkg:
  - REG_NUM_DEF=32, REG_ADDR_W=5.
  - Source index constants SRC_ALU=0, SRC_LSU=1, SRC_MULDIV=2, SRC_CSR=3.
  - typedef wb_req_t {valid, addr, data}.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ; inputs req, ptr; outputs grant one-hot and grant_idx.
  - Purely combinational, reused for future FP write-port arbitration.
- All flops stay in regfile_wb_arbiter.

Test Plan:
1. Only src1 valid, addr=5, data=64'hDEAD_BEEF → src_ready=4'b0010 same cycle; next cycle wb_write=1, wb_addr=5, wb_data=DEAD_BEEF. pend_mask[5]=1 for both cycles, 0 after.
2. All 4 valid for 8 cycles with addrs 1,2,3,4 → grant order 0,1,2,3,0,1,2,3; wb_write=1 on cycles 1..8 with wb_addr 1,2,3,4,1,2,3,4.
3. src0 addr=0, data=all-ones → src_ready[0]=1; next cycle wb_write=0; rr_ptr=1, so with src0 and src1 valid next, src1 wins.
4. flush=1 with srcs 0,2,3 valid → src_ready=0; next cycle wb_write=0. After flush drops, src0 is granted first (rr_ptr=0).
5. rst_n dropped asynchronously while wb_write=1 → wb_write, wb_addr, wb_data go to 0 before the next clock edge. After release, the first request is granted from index 0.
6. With REGFILE_WB_ARB_PERF_EN: src2 valid for 3 cycles while src0/src1 win → wait_cnt[2]=3. Without the macro, wait_cnt=0 throughout.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and request type for the integer register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int DATA_W_DEF  = 64;
  localparam int NUM_SRC_DEF = 4;

  localparam int SRC_ALU    = 0;
  localparam int SRC_LSU    = 1;
  localparam int SRC_MULDIV = 2;
  localparam int SRC_CSR    = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap-around and
// returns a one-hot grant plus its index. Shared with the future FP write port.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register-file write port.
// Optional per-source stall counters are built when REGFILE_WB_ARB_PERF_EN is defined.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter  int NUM_SRC    = NUM_SRC_DEF,
  parameter  int DATA_WIDTH = DATA_W_DEF,
  parameter  int REG_NUM    = REG_NUM_DEF,
  localparam int ADDR_W     = $clog2(REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         wb_write,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_WIDTH-1:0]        wb_data,
  output logic [REG_NUM-1:0]           pend_mask,
  output logic [NUM_SRC*32-1:0]        wait_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  accepted;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Nothing may be granted while held in reset or during a flush cycle.
  assign req = (rst_n && !flush) ? src_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_SRC)) u_rr_arbiter (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign src_ready = grant;
  assign accepted  = |grant;
  assign sel_addr  = src_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data  = src_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  // Writes to x0 are accepted and consume a turn but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_write <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      wb_write <= 1'b0;
      rr_ptr   <= '0;
    end else if (accepted) begin
      wb_write <= (sel_addr != '0);
      wb_addr  <= sel_addr;
      wb_data  <= sel_data;
      rr_ptr   <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      wb_write <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i]) begin
          pend_mask[src_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
      end
      if (wb_write) begin
        pend_mask[wb_addr] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

`ifdef REGFILE_WB_ARB_PERF_EN
  logic [31:0] wait_q [NUM_SRC];

  // Counts stalled cycles per source, flush cycles included, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && !src_ready[i] && (wait_q[i] != 32'hFFFF_FFFF)) begin
          wait_q[i] <= wait_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    wait_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      wait_cnt[i*32 +: 32] = wait_q[i];
    end
  end
`else
  assign wait_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow REGFILE_WB_ARB_PERF_EN when set.
module tb_regfile_wb_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int RN = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic [NS-1:0]   src_valid = '0;
  logic [NS*AW-1:0] src_addr = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]   src_ready;
  logic            wb_write;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [RN-1:0]   pend_mask;
  logic [NS*32-1:0] wait_cnt;

  int total = 0;
  int bad = 0;

  logic          hold_q [NS];
  logic [AW-1:0] hold_addr [NS];
  logic [DW-1:0] hold_data [NS];

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pend_mask (pend_mask),
    .wait_cnt  (wait_cnt)
  );

  always #5 clk = ~clk;

  // A source that was stalled must keep valid/addr/data stable until it is accepted.
  initial for (int i = 0; i < NS; i++) hold_q[i] = 1'b0;
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      for (int i = 0; i < NS; i++) begin
        if (hold_q[i]) begin
          total++;
          if (src_valid[i] !== 1'b1 || src_addr[i*AW +: AW] !== hold_addr[i] ||
              src_data[i*DW +: DW] !== hold_data[i]) begin
            bad++;
            $display("[TB] FAIL protocol_hold src%0d: valid=%b addr=%0d want addr=%0d", i,
                     src_valid[i], src_addr[i*AW +: AW], hold_addr[i]);
          end
        end
        hold_q[i]    = src_valid[i] && !src_ready[i];
        hold_addr[i] = src_addr[i*AW +: AW];
        hold_data[i] = src_data[i*DW +: DW];
      end
    end else begin
      for (int i = 0; i < NS; i++) hold_q[i] = 1'b0;
    end
  end

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[i]         = v;
    src_addr[i*AW +: AW] = a;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, AW'(i + 1), DW'(i));
    #1 rst_n = 1'b0;
    #1;
    total++; if (wb_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb_write: got %b want 0", wb_write); end
    total++; if (wb_addr !== '0) begin bad++; $display("[TB] FAIL reset_wb_addr: got %0d want 0", wb_addr); end
    total++; if (wb_data !== '0) begin bad++; $display("[TB] FAIL reset_wb_data: got %h want 0", wb_data); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0000", src_ready); end
    total++; if (pend_mask !== '0) begin bad++; $display("[TB] FAIL reset_pend: got %h want 0", pend_mask); end
    total++; if (wait_cnt !== '0) begin bad++; $display("[TB] FAIL reset_wait_cnt: got %h want 0", wait_cnt); end
    step();
    step();
    src_valid = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_src(1, 1'b1, 5'd5, 64'hDEAD_BEEF);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("[TB] FAIL single_ready: got %b want 0010", src_ready); end
    total++; if (pend_mask !== 32'h0000_0020) begin bad++; $display("[TB] FAIL single_pend0: got %h want 00000020", pend_mask); end
    step();
    set_src(1, 1'b0, '0, '0);
    #1;
    total++; if (wb_write !== 1'b1) begin bad++; $display("[TB] FAIL single_wb_write: got %b want 1", wb_write); end
    total++; if (wb_addr !== 5'd5) begin bad++; $display("[TB] FAIL single_wb_addr: got %0d want 5", wb_addr); end
    total++; if (wb_data !== 64'hDEAD_BEEF) begin bad++; $display("[TB] FAIL single_wb_data: got %h want deadbeef", wb_data); end
    total++; if (pend_mask !== 32'h0000_0020) begin bad++; $display("[TB] FAIL single_pend1: got %h want 00000020", pend_mask); end
    step();
    total++; if (wb_write !== 1'b0) begin bad++; $display("[TB] FAIL single_wb_idle: got %b want 0", wb_write); end
    total++; if (pend_mask !== '0) begin bad++; $display("[TB] FAIL single_pend2: got %h want 0", pend_mask); end
  endtask

  task automatic test_rotation();
    logic [NS-1:0] exp_ready;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, AW'(i + 1), DW'(64'h100 + i));
    for (int k = 0; k < 8; k++) begin
      exp_ready = NS'(1 << (k % NS));
      #1;
      total++; if (src_ready !== exp_ready) begin bad++; $display("[TB] FAIL rot_ready%0d: got %b want %b", k, src_ready, exp_ready); end
      if (k > 0) begin
        total++;
        if (wb_write !== 1'b1 || wb_addr !== AW'(((k - 1) % NS) + 1)) begin
          bad++; $display("[TB] FAIL rot_wb%0d: got write=%b addr=%0d want write=1 addr=%0d", k, wb_write, wb_addr, ((k - 1) % NS) + 1);
        end
      end
      step();
      if (k >= NS) set_src(k % NS, 1'b0, '0, '0);
    end
    #1;
    total++;
    if (wb_write !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 64'h103) begin
      bad++; $display("[TB] FAIL rot_last: got write=%b addr=%0d data=%h want 1/4/103", wb_write, wb_addr, wb_data);
    end
    step();
  endtask

  task automatic test_x0();
    set_src(0, 1'b1, 5'd0, '1);
    #1;
    total++; if (src_ready !== 4'b0001) begin bad++; $display("[TB] FAIL x0_ready: got %b want 0001", src_ready); end
    total++; if (pend_mask !== '0) begin bad++; $display("[TB] FAIL x0_pend: got %h want 0", pend_mask); end
    step();
    set_src(0, 1'b1, 5'd7, 64'h7);
    set_src(1, 1'b1, 5'd8, 64'h8);
    #1;
    total++; if (wb_write !== 1'b0) begin bad++; $display("[TB] FAIL x0_wb_write: got %b want 0", wb_write); end
    total++; if (wb_data !== '1) begin bad++; $display("[TB] FAIL x0_wb_data: got %h want all-ones", wb_data); end
    total++; if (src_ready !== 4'b0010) begin bad++; $display("[TB] FAIL x0_next_ready: got %b want 0010", src_ready); end
    total++; if (pend_mask !== 32'h0000_0180) begin bad++; $display("[TB] FAIL x0_pend2: got %h want 00000180", pend_mask); end
    step();
    set_src(1, 1'b0, '0, '0);
    #1;
    total++; if (wb_write !== 1'b1 || wb_addr !== 5'd8) begin bad++; $display("[TB] FAIL x0_wb8: got write=%b addr=%0d want 1/8", wb_write, wb_addr); end
    total++; if (src_ready !== 4'b0001) begin bad++; $display("[TB] FAIL x0_src0_ready: got %b want 0001", src_ready); end
    step();
    set_src(0, 1'b0, '0, '0);
    #1;
    total++; if (wb_write !== 1'b1 || wb_addr !== 5'd7) begin bad++; $display("[TB] FAIL x0_wb7: got write=%b addr=%0d want 1/7", wb_write, wb_addr); end
    step();
  endtask

  task automatic test_flush();
    set_src(2, 1'b1, 5'd12, 64'hC);
    #1;
    total++; if (src_ready !== 4'b0100) begin bad++; $display("[TB] FAIL flush_pre_ready: got %b want 0100", src_ready); end
    step();
    flush = 1'b1;
    set_src(0, 1'b1, 5'd9, 64'h9);
    set_src(2, 1'b1, 5'd10, 64'hA);
    set_src(3, 1'b1, 5'd11, 64'hB);
    #1;
    total++; if (src_ready !== 4'b0000) begin bad++; $display("[TB] FAIL flush_ready: got %b want 0000", src_ready); end
    total++; if (wb_write !== 1'b1 || wb_addr !== 5'd12) begin bad++; $display("[TB] FAIL flush_inflight: got write=%b addr=%0d want 1/12", wb_write, wb_addr); end
    total++; if (pend_mask !== 32'h0000_1E00) begin bad++; $display("[TB] FAIL flush_pend: got %h want 00001e00", pend_mask); end
    step();
    flush = 1'b0;
    #1;
    total++; if (wb_write !== 1'b0) begin bad++; $display("[TB] FAIL flush_wb_write: got %b want 0", wb_write); end
    total++; if (src_ready !== 4'b0001) begin bad++; $display("[TB] FAIL flush_after_ready: got %b want 0001", src_ready); end
    step();
    set_src(0, 1'b0, '0, '0);
    #1;
    total++; if (src_ready !== 4'b0100) begin bad++; $display("[TB] FAIL flush_ready2: got %b want 0100", src_ready); end
    total++; if (wb_write !== 1'b1 || wb_addr !== 5'd9) begin bad++; $display("[TB] FAIL flush_wb9: got write=%b addr=%0d want 1/9", wb_write, wb_addr); end
    step();
    set_src(2, 1'b0, '0, '0);
    #1;
    total++; if (src_ready !== 4'b1000) begin bad++; $display("[TB] FAIL flush_ready3: got %b want 1000", src_ready); end
    step();
    set_src(3, 1'b0, '0, '0);
    #1;
    total++; if (wb_addr !== 5'd11 || wb_data !== 64'hB) begin bad++; $display("[TB] FAIL flush_wb11: got addr=%0d data=%h want 11/b", wb_addr, wb_data); end
    step();
  endtask

  task automatic test_async_reset();
    set_src(1, 1'b1, 5'd6, 64'h66);
    step();
    set_src(1, 1'b0, '0, '0);
    #1;
    total++; if (wb_write !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre: got %b want 1", wb_write); end
    set_src(3, 1'b1, 5'd3, 64'h3);
    #1 rst_n = 1'b0;
    #1;
    total++; if (wb_write !== 1'b0) begin bad++; $display("[TB] FAIL areset_wb_write: got %b want 0", wb_write); end
    total++; if (wb_addr !== '0 || wb_data !== '0) begin bad++; $display("[TB] FAIL areset_wb_bus: got addr=%0d data=%h want 0/0", wb_addr, wb_data); end
    total++; if (src_ready !== 4'b0000 || pend_mask !== '0) begin bad++; $display("[TB] FAIL areset_outs: got ready=%b pend=%h want 0/0", src_ready, pend_mask); end
    set_src(3, 1'b0, '0, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    set_src(0, 1'b1, 5'd1, 64'h1);
    set_src(3, 1'b1, 5'd3, 64'h3);
    #1;
    total++; if (src_ready !== 4'b0001) begin bad++; $display("[TB] FAIL areset_first: got %b want 0001", src_ready); end
    step();
    set_src(0, 1'b0, '0, '0);
    #1;
    total++; if (src_ready !== 4'b1000) begin bad++; $display("[TB] FAIL areset_second: got %b want 1000", src_ready); end
    step();
    set_src(3, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_perf();
    logic [NS*32-1:0] exp_cnt;
`ifdef REGFILE_WB_ARB_PERF_EN
    exp_cnt = {32'd1, 32'd3, 32'd2, 32'd1};
`else
    exp_cnt = '0;
`endif
    flush = 1'b1;
    set_src(0, 1'b1, 5'd1, 64'h1);
    set_src(1, 1'b1, 5'd2, 64'h2);
    set_src(2, 1'b1, 5'd3, 64'h3);
    #1;
    total++; if (src_ready !== 4'b0000) begin bad++; $display("[TB] FAIL perf_flush_ready: got %b want 0000", src_ready); end
    step();
    flush = 1'b0;
    #1;
    total++; if (src_ready !== 4'b0001) begin bad++; $display("[TB] FAIL perf_ready0: got %b want 0001", src_ready); end
    step();
    set_src(0, 1'b0, '0, '0);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("[TB] FAIL perf_ready1: got %b want 0010", src_ready); end
    step();
    set_src(1, 1'b0, '0, '0);
    #1;
    total++; if (src_ready !== 4'b0100) begin bad++; $display("[TB] FAIL perf_ready2: got %b want 0100", src_ready); end
    step();
    set_src(2, 1'b0, '0, '0);
    #1;
    total++; if (wait_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL perf_wait_cnt: got %h want %h", wait_cnt, exp_cnt); end
    total++; if (wait_cnt[64 +: 32] !== exp_cnt[64 +: 32]) begin bad++; $display("[TB] FAIL perf_src2: got %0d want %0d", wait_cnt[64 +: 32], exp_cnt[64 +: 32]); end
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_x0();
    test_flush();
    test_async_reset();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
